// File: rtl/pattern_stamper.sv
// Stamps an 8x8 cell pattern into packed board memory at a cursor, one
// read-modify-write per covered word, only while the renderer is blanking.
module pattern_stamper #(
   parameter int WORD_SIZE      = 16,
   parameter int LOG_WORD_SIZE  = 4,
   parameter int BOARD_SIZE     = 256,
   parameter int LOG_BOARD_SIZE = 8,
   parameter int LOG_MAX_ADDR   = 12,
   parameter int READ_LATENCY   = 2
) (
   input  logic                      clk_in,
   input  logic                      rst_in,
   input  logic                      start_in,
   input  logic [1:0]                mode_in,
   input  logic [63:0]               pattern_in,
   input  logic [LOG_BOARD_SIZE-1:0] cursor_x_in,
   input  logic [LOG_BOARD_SIZE-1:0] cursor_y_in,
   input  logic                      render_done_in,
   input  logic [WORD_SIZE-1:0]      data_r_in,
   output logic [LOG_MAX_ADDR-1:0]   addr_out,
   output logic [WORD_SIZE-1:0]      data_w_out,
   output logic                      we_out,
   output logic                      busy_out,
   output logic                      done_out
);

   localparam int COLW = LOG_BOARD_SIZE - LOG_WORD_SIZE;
   localparam int LATW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_WIN, S_READ, S_WAIT, S_WRITE, S_DONE
   } state_t;

   state_t                    state_q;
   logic [1:0]                mode_q;
   logic [63:0]               pattern_q;
   logic [LOG_BOARD_SIZE-1:0] cx_q, cy_q;
   logic [2:0]                row_q;
   logic                      wordb_q;
   logic [LATW-1:0]           lat_q;
   logic [LOG_MAX_ADDR-1:0]   addr_q;
   logic [WORD_SIZE-1:0]      dataw_q;
   logic                      we_q, busy_q, done_q;

   logic [LOG_WORD_SIZE-1:0]  off;
   logic                      need_b, last_word;
   logic [2:0]                nxt_row;
   logic                      nxt_wordb;
   logic [7:0]                prow;
   logic [WORD_SIZE+7:0]      ext_p, ext_m;
   logic [WORD_SIZE-1:0]      place_p, place_m, merged_d;
   logic [LOG_MAX_ADDR-1:0]   cur_addr_d, nxt_addr_d;

   function automatic logic [LOG_MAX_ADDR-1:0] word_addr(
      input logic [LOG_BOARD_SIZE-1:0] y,
      input logic [COLW-1:0]           col,
      input logic [2:0]                row,
      input logic                      b);
      logic [LOG_BOARD_SIZE-1:0] yr;
      logic [COLW-1:0]           cr;
      yr = y + LOG_BOARD_SIZE'(row);
      cr = col + COLW'(b);
      return LOG_MAX_ADDR'({yr, cr});
   endfunction

   always_comb begin
      off       = cx_q[LOG_WORD_SIZE-1:0];
      need_b    = off > LOG_WORD_SIZE'(WORD_SIZE - 8);
      last_word = (row_q == 3'd7) && (wordb_q || !need_b);
      if (!wordb_q && need_b) begin
         nxt_row   = row_q;
         nxt_wordb = 1'b1;
      end else begin
         nxt_row   = row_q + 3'd1;
         nxt_wordb = 1'b0;
      end
      cur_addr_d = word_addr(cy_q, cx_q[LOG_BOARD_SIZE-1:LOG_WORD_SIZE], row_q, wordb_q);
      nxt_addr_d = word_addr(cy_q, cx_q[LOG_BOARD_SIZE-1:LOG_WORD_SIZE], nxt_row, nxt_wordb);
      // Shift the 8-cell row across a word-plus-8 window; the low 8 bits spill into word B.
      prow    = pattern_q[{~row_q, 3'b000} +: 8];
      ext_p   = {prow, {WORD_SIZE{1'b0}}} >> off;
      ext_m   = {8'hFF, {WORD_SIZE{1'b0}}} >> off;
      place_p = wordb_q ? {ext_p[7:0], {(WORD_SIZE-8){1'b0}}} : ext_p[WORD_SIZE+7:8];
      place_m = wordb_q ? {ext_m[7:0], {(WORD_SIZE-8){1'b0}}} : ext_m[WORD_SIZE+7:8];
      case (mode_q)
         2'b00:   merged_d = data_r_in | place_p;
         2'b01:   merged_d = data_r_in ^ place_p;
         2'b10:   merged_d = data_r_in & ~place_p;
         default: merged_d = (data_r_in & ~place_m) | place_p;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q   <= S_IDLE;
         mode_q    <= '0;
         pattern_q <= '0;
         cx_q      <= '0;
         cy_q      <= '0;
         row_q     <= '0;
         wordb_q   <= 1'b0;
         lat_q     <= '0;
         addr_q    <= '0;
         dataw_q   <= '0;
         we_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_in) begin
                  mode_q    <= mode_in;
                  pattern_q <= pattern_in;
                  cx_q      <= cursor_x_in;
                  cy_q      <= cursor_y_in;
                  row_q     <= '0;
                  wordb_q   <= 1'b0;
                  busy_q    <= 1'b1;
                  if (render_done_in) begin
                     addr_q  <= word_addr(cursor_y_in,
                                          cursor_x_in[LOG_BOARD_SIZE-1:LOG_WORD_SIZE],
                                          3'd0, 1'b0);
                     state_q <= S_READ;
                  end else begin
                     state_q <= S_WAIT_WIN;
                  end
               end
            end
            S_WAIT_WIN: begin
               if (render_done_in) begin
                  addr_q  <= cur_addr_d;
                  state_q <= S_READ;
               end
            end
            S_READ: begin
               lat_q   <= '0;
               state_q <= render_done_in ? S_WAIT : S_WAIT_WIN;
            end
            S_WAIT: begin
               if (!render_done_in) begin
                  state_q <= S_WAIT_WIN;
               end else if (lat_q == LATW'(READ_LATENCY - 1)) begin
                  dataw_q <= merged_d;
                  we_q    <= 1'b1;
                  state_q <= S_WRITE;
               end else begin
                  lat_q <= lat_q + 1'b1;
               end
            end
            S_WRITE: begin
               we_q <= 1'b0;
               if (!render_done_in) begin
                  state_q <= S_WAIT_WIN;
               end else if (last_word) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_DONE;
               end else begin
                  row_q   <= nxt_row;
                  wordb_q <= nxt_wordb;
                  addr_q  <= nxt_addr_d;
                  state_q <= S_READ;
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // A window drop during the WRITE cycle itself must suppress the strobe immediately.
   assign we_out     = we_q & render_done_in;
   assign addr_out   = addr_q;
   assign data_w_out = dataw_q;
   assign busy_out   = busy_q;
   assign done_out   = done_q;

endmodule

// File: tb/tb_pattern_stamper.sv
// Bench for pattern_stamper: board memory model with 2-cycle read latency and
// a cell-level reference of the stamp operation.
module tb_pattern_stamper;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        start_in;
   logic [1:0]  mode_in;
   logic [63:0] pattern_in;
   logic [7:0]  cursor_x_in, cursor_y_in;
   logic        render_done_in;
   logic [15:0] data_r_in;
   logic [11:0] addr_out;
   logic [15:0] data_w_out;
   logic        we_out, busy_out, done_out;

   int checks   = 0;
   int failures = 0;

   pattern_stamper #(
      .WORD_SIZE(16), .LOG_WORD_SIZE(4), .BOARD_SIZE(256),
      .LOG_BOARD_SIZE(8), .LOG_MAX_ADDR(12), .READ_LATENCY(2)
   ) dut (
      .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .mode_in(mode_in),
      .pattern_in(pattern_in), .cursor_x_in(cursor_x_in), .cursor_y_in(cursor_y_in),
      .render_done_in(render_done_in), .data_r_in(data_r_in), .addr_out(addr_out),
      .data_w_out(data_w_out), .we_out(we_out), .busy_out(busy_out), .done_out(done_out)
   );

   always #5 clk_in = ~clk_in;

   logic [15:0] mem [0:4095];
   logic [15:0] p1 = '0, p2 = '0;
   logic        fill_req = 1'b0;
   logic        fill_rand = 1'b0;
   logic [15:0] fill_val = '0;
   int unsigned fill_seed = 0;
   assign data_r_in = p2;

   function automatic logic [15:0] hashw(int unsigned i, int unsigned s);
      return 16'((i * 32'd40503) ^ (s * 32'd2654435761) ^ (i >> 5));
   endfunction

   always @(posedge clk_in) begin
      if (fill_req) begin
         for (int i = 0; i < 4096; i++)
            mem[i] <= fill_rand ? hashw(i, fill_seed) : fill_val;
      end else if (we_out) begin
         mem[addr_out] <= data_w_out;
      end
      p1 <= mem[addr_out];
      p2 <= p1;
   end

   logic [15:0] ref_mem [0:4095];
   logic [15:0] snap    [0:4095];
   int exp_addrs [0:15];
   int exp_n;
   int wlog [0:63];
   int nw, done_n;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic fill(input logic [15:0] v, input logic rnd, input int unsigned seed);
      @(negedge clk_in);
      fill_val = v; fill_rand = rnd; fill_seed = seed; fill_req = 1'b1;
      @(posedge clk_in);
      @(negedge clk_in);
      fill_req = 1'b0;
      ref_mem = mem;
   endtask

   // Cell-by-cell reference: each pattern cell lands on one board cell with wrap.
   task automatic apply_ref(input logic [1:0] mode, input logic [63:0] pat,
                            input int x, input int y);
      exp_n = 0;
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) begin
            int xx, yy, w, b;
            logic p;
            p  = pat[63 - 8*r - c];
            xx = (x + c) % 256;
            yy = (y + r) % 256;
            w  = yy * 16 + xx / 16;
            b  = 15 - (xx % 16);
            if (exp_n == 0 || exp_addrs[exp_n-1] != w) begin
               exp_addrs[exp_n] = w;
               exp_n++;
            end
            case (mode)
               2'd0: if (p) ref_mem[w][b] = 1'b1;
               2'd1: if (p) ref_mem[w][b] = ~ref_mem[w][b];
               2'd2: if (p) ref_mem[w][b] = 1'b0;
               default: ref_mem[w][b] = p;
            endcase
         end
      end
   endtask

   task automatic run_stamp(input logic [1:0] mode, input logic [63:0] pat,
                            input logic [7:0] x, input logic [7:0] y,
                            input int drop_at, input int busy_start_at);
      int n;
      nw = 0; done_n = -1;
      @(negedge clk_in);
      start_in = 1'b1; mode_in = mode; pattern_in = pat;
      cursor_x_in = x; cursor_y_in = y;
      @(posedge clk_in);
      @(negedge clk_in);
      start_in = 1'b0;
      n = 1;
      chk("busy_after_start", busy_out, 1'b1);
      while (n <= 300) begin
         if (we_out) begin
            if (nw < 64) wlog[nw] = addr_out;
            nw++;
         end
         if (done_out) begin
            done_n = n;
            chk("busy_at_done", busy_out, 1'b0);
            break;
         end
         if (n == drop_at) render_done_in = 1'b0;
         if (drop_at > 0 && n == drop_at + 3) render_done_in = 1'b1;
         if (n == busy_start_at) begin
            start_in = 1'b1; pattern_in = ~pat; cursor_x_in = x + 8'd40;
         end
         if (busy_start_at > 0 && n == busy_start_at + 1) start_in = 1'b0;
         @(negedge clk_in);
         n++;
      end
      if (done_n < 0) chk("done_timeout", 1'b0, 1'b1);
      start_in = 1'b0;
      render_done_in = 1'b1;
   endtask

   task automatic cmp_mem(input string name);
      int bad = 0;
      for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) bad++;
      chk(name, bad, 0);
   endtask

   task automatic cmp_order(input string name);
      int bad = 0;
      if (nw != exp_n) bad = 100 + nw;
      else for (int i = 0; i < exp_n; i++) if (wlog[i] != exp_addrs[i]) bad++;
      chk(name, bad, 0);
   endtask

   typedef struct {
      logic [1:0]  mode;
      logic [63:0] pat;
      logic [7:0]  x, y;
      logic [15:0] fill;
      int          a0; logic [15:0] d0;
      int          a1; logic [15:0] d1;
      int          nwr;
      int          dn;
   } vec_t;
   vec_t vt [7];

   initial begin
      vt[0] = '{2'd0, 64'hFF00_0000_0000_0000, 8'd0,   8'd0,   16'h0000, 0,    16'hFF00, 16,   16'h0000, 8,  33};
      vt[1] = '{2'd0, 64'hFF00_0000_0000_0000, 8'd12,  8'd0,   16'h0000, 0,    16'h000F, 1,    16'hF000, 16, 65};
      vt[2] = '{2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'd252, 8'd254, 16'h0000, 4079, 16'h000F, 4064, 16'hF000, 16, 65};
      vt[3] = '{2'd3, 64'h0000_0000_0000_0000, 8'd4,   8'd0,   16'hFFFF, 0,    16'hF00F, 16,   16'hF00F, 8,  33};
      vt[4] = '{2'd2, 64'hA500_0000_0000_0000, 8'd0,   8'd0,   16'hFFFF, 0,    16'h5AFF, 16,   16'hFFFF, 8,  33};
      vt[5] = '{2'd1, 64'hFF00_0000_0000_0000, 8'd8,   8'd3,   16'h1234, 48,   16'h12CB, 64,   16'h1234, 8,  33};
      vt[6] = '{2'd0, 64'hFF00_0000_0000_0000, 8'd9,   8'd0,   16'h0000, 0,    16'h007F, 1,    16'h8000, 16, 65};

      rst_in = 1'b0; start_in = 1'b0; mode_in = '0; pattern_in = '0;
      cursor_x_in = '0; cursor_y_in = '0; render_done_in = 1'b1;
      repeat (3) @(negedge clk_in);
      chk("rst_addr", addr_out, 12'd0);
      chk("rst_we_busy_done", {we_out, busy_out, done_out}, 3'b000);
      rst_in = 1'b1;

      // Asynchronous reset in the middle of a stamp, during a WRITE cycle.
      fill(16'h0000, 1'b0, 0);
      @(negedge clk_in);
      start_in = 1'b1; mode_in = 2'd0; pattern_in = 64'hFF00_0000_0000_0000;
      cursor_x_in = 8'd16; cursor_y_in = 8'd1;
      @(posedge clk_in);
      @(negedge clk_in);
      start_in = 1'b0;
      repeat (3) @(negedge clk_in);
      chk("pre_rst_we", we_out, 1'b1);
      #1 rst_in = 1'b0;
      #1;
      chk("async_rst_outs", {addr_out, data_w_out, we_out, busy_out, done_out}, 31'd0);
      #1 rst_in = 1'b1;

      for (int i = 0; i < 7; i++) begin
         fill(vt[i].fill, 1'b0, 0);
         apply_ref(vt[i].mode, vt[i].pat, vt[i].x, vt[i].y);
         run_stamp(vt[i].mode, vt[i].pat, vt[i].x, vt[i].y, 0, 0);
         @(negedge clk_in);
         chk($sformatf("v%0d_writes", i), nw, vt[i].nwr);
         chk($sformatf("v%0d_done_cycle", i), done_n, vt[i].dn);
         chk($sformatf("v%0d_word0", i), mem[vt[i].a0], vt[i].d0);
         chk($sformatf("v%0d_word1", i), mem[vt[i].a1], vt[i].d1);
         cmp_order($sformatf("v%0d_order", i));
         cmp_mem($sformatf("v%0d_mem", i));
         if (i == 2) chk("wrap_row2_words", {wlog[4], wlog[5]}, {32'd15, 32'd0});
      end

      // Window drop during WAIT of word 3, plus an ignored start while busy.
      fill(16'h0F0F, 1'b0, 0);
      apply_ref(2'd1, 64'h8142_2418_1824_4281, 8'd32, 8'd100);
      run_stamp(2'd1, 64'h8142_2418_1824_4281, 8'd32, 8'd100, 14, 5);
      @(negedge clk_in);
      chk("drop_writes", nw, 8);
      chk("drop_done_cycle", done_n, 38);
      cmp_order("drop_order");
      cmp_mem("drop_mem");

      // XOR applied twice restores memory.
      fill(16'h0000, 1'b1, 32'd77);
      snap = ref_mem;
      run_stamp(2'd1, 64'hDEAD_BEEF_0123_4567, 8'd201, 8'd250, 0, 0);
      run_stamp(2'd1, 64'hDEAD_BEEF_0123_4567, 8'd201, 8'd250, 0, 0);
      @(negedge clk_in);
      ref_mem = snap;
      cmp_mem("xor_twice");

      for (int k = 0; k < 24; k++) begin
         logic [1:0]  m;
         logic [63:0] pt;
         logic [7:0]  rx, ry;
         m  = 2'($urandom_range(0, 3));
         pt = {$urandom, $urandom};
         rx = 8'($urandom);
         ry = 8'($urandom);
         fill(16'h0000, 1'b1, $urandom);
         apply_ref(m, pt, rx, ry);
         run_stamp(m, pt, rx, ry, 0, 0);
         @(negedge clk_in);
         chk($sformatf("rnd%0d_done_cycle", k), done_n, 1 + 4*exp_n);
         cmp_order($sformatf("rnd%0d_order", k));
         cmp_mem($sformatf("rnd%0d_mem", k));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
